// File: rtl/t_flip_flop.sv
// Bank of WIDTH toggle flip-flops with async active-low clear and a serial scan path.
// Define T_FLIP_FLOP_SELF_CHECK_EN to build a duplicate shadow register that raises fault on divergence.
module t_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] t,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    output logic [WIDTH-1:0] q,
    output logic             fault
);

    // Shared by the main and shadow copies so both see identical next-state logic.
    // The left shift drops the top bit and opens bit 0 for scan_in, which also covers WIDTH = 1.
    function automatic logic [WIDTH-1:0] next_state(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tog,
        input logic             se,
        input logic             si
    );
        return se ? ((cur << 1) | WIDTH'(si)) : (cur ^ tog);
    endfunction

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = next_state(q_q, t, scan_en, scan_in);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign scan_out = q_q[WIDTH-1];

`ifdef T_FLIP_FLOP_SELF_CHECK_EN
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic             fault_q;

    assign shadow_d = next_state(shadow_q, t, scan_en, scan_in);

    // Not sticky: fault reflects only the most recent edge's comparison.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            shadow_q <= RESET_VALUE;
            fault_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            fault_q  <= (q_d != shadow_d);
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: a 1-bit instance for reset/toggle/clear sequences
// and a 4-bit instance driven from a vector table for per-bit toggle and scan.
module tb_t_flip_flop;

    logic       clk = 1'b0;
    logic       clear1_n, clear4_n;
    logic       t1, se1, si1, so1, q1, fault1;
    logic [3:0] t4, q4;
    logic       se4, si4, so4, fault4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    t_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk), .clear_n(clear1_n), .t(t1), .scan_en(se1), .scan_in(si1),
        .scan_out(so1), .q(q1), .fault(fault1)
    );

    t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000)) u4 (
        .clk(clk), .clear_n(clear4_n), .t(t4), .scan_en(se4), .scan_in(si4),
        .scan_out(so4), .q(q4), .fault(fault4)
    );

    typedef struct packed {
        logic       se;
        logic       si;
        logic [3:0] t;
        logic [3:0] exp_q;
        logic       exp_so;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Starting from q = 0000 after reset.
        vecs[0]  = '{se:1'b0, si:1'b0, t:4'b1010, exp_q:4'b1010, exp_so:1'b1};
        vecs[1]  = '{se:1'b0, si:1'b0, t:4'b0110, exp_q:4'b1100, exp_so:1'b1};
        vecs[2]  = '{se:1'b0, si:1'b0, t:4'b0000, exp_q:4'b1100, exp_so:1'b1};
        vecs[3]  = '{se:1'b0, si:1'b0, t:4'b1111, exp_q:4'b0011, exp_so:1'b0};
        vecs[4]  = '{se:1'b1, si:1'b1, t:4'b1111, exp_q:4'b0111, exp_so:1'b0};
        vecs[5]  = '{se:1'b1, si:1'b0, t:4'b1111, exp_q:4'b1110, exp_so:1'b1};
        vecs[6]  = '{se:1'b1, si:1'b1, t:4'b1111, exp_q:4'b1101, exp_so:1'b1};
        vecs[7]  = '{se:1'b1, si:1'b1, t:4'b1111, exp_q:4'b1011, exp_so:1'b1};
        vecs[8]  = '{se:1'b0, si:1'b1, t:4'b1111, exp_q:4'b0100, exp_so:1'b0};
        vecs[9]  = '{se:1'b0, si:1'b0, t:4'b0000, exp_q:4'b0100, exp_so:1'b0};
        vecs[10] = '{se:1'b0, si:1'b0, t:4'b0001, exp_q:4'b0101, exp_so:1'b0};

        clear1_n = 1'b0; clear4_n = 1'b0;
        t1 = 1'b1; se1 = 1'b0; si1 = 1'b0;
        t4 = 4'b1111; se4 = 1'b0; si4 = 1'b0;

        // Clear dominates t and the clock.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_q1", 64'(q1), 64'd0);
            chk("reset_fault1", 64'(fault1), 64'd0);
            chk("reset_q4", 64'(q4), 64'd0);
        end

        clear1_n = 1'b1; clear4_n = 1'b1;
        t4 = 4'b0000;

        for (int i = 0; i < 4; i++) begin
            step();
            chk("toggle_q1", 64'(q1), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("toggle_so1", 64'(so1), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        t1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q1", 64'(q1), 64'd0);
        end

        t1 = 1'b1;
        step();
        chk("pre_clear_q1", 64'(q1), 64'd1);
        #2 clear1_n = 1'b0;
        #1 chk("midcycle_clear_q1", 64'(q1), 64'd0);
        step();
        chk("clear_held_q1", 64'(q1), 64'd0);
        clear1_n = 1'b1;
        step();
        chk("release_q1", 64'(q1), 64'd1);

        chk("u4_start_q", 64'(q4), 64'd0);
        for (int i = 0; i < 11; i++) begin
            se4 = vecs[i].se; si4 = vecs[i].si; t4 = vecs[i].t;
            step();
            chk($sformatf("vec%0d_q4", i), 64'(q4), 64'(vecs[i].exp_q));
            chk($sformatf("vec%0d_so4", i), 64'(so4), 64'(vecs[i].exp_so));
            chk($sformatf("vec%0d_fault4", i), 64'(fault4), 64'd0);
        end

`ifdef T_FLIP_FLOP_SELF_CHECK_EN
        // In scan mode with WIDTH = 1 the next state is just scan_in, so the shadow heals after one edge.
        t1 = 1'b0; se1 = 1'b1; si1 = 1'b0;
        step();
        chk("sc_pre_fault1", 64'(fault1), 64'd0);
        force u1.shadow_d = 1'b1;
        step();
        release u1.shadow_d;
        chk("sc_fault_set", 64'(fault1), 64'd1);
        chk("sc_q1", 64'(q1), 64'd0);
        step();
        chk("sc_fault_clear", 64'(fault1), 64'd0);
        step();
        chk("sc_fault_stay0", 64'(fault1), 64'd0);
        se1 = 1'b0;
`else
        t1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nosc_fault1", 64'(fault1), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t_flip_flop.md
# t_flip_flop

Bank of toggle flip-flops with an asynchronous active-low clear, a DFT scan path and an optional duplicate-register self-check. Each bit inverts its state on a rising clock edge when its toggle input is 1, and holds otherwise. The block serves as the basic counting/toggle cell in the DFT test vehicle. With default parameters it is a drop-in single-bit T flip-flop.

## Interface
- WIDTH, 1: number of independent toggle bits (1..64).
- RESET_VALUE, 0: value loaded into q while clear_n is low. Width WIDTH; bit i applies to q[i].
- clk  input  1  rising-edge clock; the only clock.
- clear_n  input  1  reset, asynchronous, active-low.
- t  input  WIDTH  per-bit toggle request.
- scan_en  input  1  1 = scan shift mode; 0 = functional mode.
- scan_in  input  1  serial scan data, enters q[0].
- scan_out  output  1  serial scan data, equals q[WIDTH-1].
- q  output  WIDTH  flip-flop state, registered.
- fault  output  1  self-check mismatch flag, registered.

## Operation
- Reset (clear_n = 0):
  - q = RESET_VALUE; shadow register = RESET_VALUE; fault = 0.
  - Takes effect immediately, with no clock required.
  - Dominates t, scan_en and the clock.
- Functional mode (clear_n = 1, scan_en = 0), at each rising clk edge:
  - q[i] <= q[i] ^ t[i], for each bit independently.
  - t[i] = 0: q[i] holds. t[i] = 1: q[i] inverts.
- Scan mode (clear_n = 1, scan_en = 1), at each rising clk edge:
  - q <= {q[WIDTH-2:0], scan_in}. For WIDTH = 1: q <= scan_in.
  - t is ignored.
- scan_out = q[WIDTH-1], combinational from the register. It is valid in both modes.
- Self-check (when compiled in):
  - A shadow register of width WIDTH receives the same next-state logic from the same inputs.
  - fault <= (q_next != shadow_next) each cycle. It is registered and not sticky.
  - It is therefore 1 exactly for cycles in which the two copies disagree.
- X/Z on t or scan_en with clear_n = 1 is not defined behaviour. The bench does not drive it.

## Timing
- Latency: one clock. q reflects t sampled at edge n immediately after edge n.
- No combinational path from t to q.
- Asynchronous assert:
  - q goes to RESET_VALUE within the clear-to-output delay.
  - This includes mid-cycle assertion and assertion concurrent with a clock edge.
- Deassert:
  - The first active edge is the first rising clk with clear_n sampled 1.
  - Designers synchronize the clear_n release externally. The block adds no synchronizer.
- A scan_en change takes effect at the next rising edge. No dead cycle.
- fault is valid one cycle after the disagreeing next-state evaluation. It is 0 throughout reset.

## Configuration
- T_FLIP_FLOP_SELF_CHECK_EN:
  - Defined: the shadow register and comparator are built, and fault is driven as described.
  - Undefined: no shadow logic is built, fault is tied to constant 0, and q/scan behaviour is unchanged.

## Test plan
- Reset: hold clear_n = 0 with t = 1 for 3 clocks, WIDTH = 1, RESET_VALUE = 0 -> q = 0 throughout and fault = 0.
- Toggle: clear_n = 1, t = 1 for 4 edges starting from q = 0 -> q = 1, 0, 1, 0. Then t = 0 for 3 edges -> q holds 0.
- Mid-cycle clear: q = 1, drop clear_n between edges -> q = 0 before the next edge. Release with t = 1 -> q = 1 after the first edge with clear_n = 1.
- Per-bit independence: WIDTH = 4, q = 4'b0000, t = 4'b1010 for 1 edge -> q = 4'b1010. t = 4'b0110 -> q = 4'b1100.
- Scan: WIDTH = 4, scan_en = 1, scan_in sequence 1, 0, 1, 1 -> q = 4'b1011 after 4 edges, with scan_out showing the prior q[3] each cycle. scan_en = 0, t = 4'b1111 -> q = 4'b0100.
- Self-check: with T_FLIP_FLOP_SELF_CHECK_EN defined, force the shadow bit 0 for one cycle -> fault = 1 for exactly one cycle, then 0. Without the macro -> fault = 0 always.
